mult_arbiter: RTL

//   Shares one sequential shift-add multiplier core (8x8, result valid 9 cycles after operand launch) between

---
 rtl/mult_arb_pkg.sv | 13 +
 rtl/mult_arbiter_if.sv | 29 ++
 rtl/mult_arbiter_rr_arbiter.sv | 30 +++
 rtl/mult_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
package mult_arb_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

   localparam int W_DEF    = 8;
   localparam int CORE_LAT = W_DEF + 1;

   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Client-facing request/response bundle of the multiplier arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
// valid must not depend on ready, and payload is held stable while valid waits for ready.
interface mult_arbiter_if
   import mult_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = idw(NREQ)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_data;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = idw(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o
);
   logic found;
   int   k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = 0;
      for (int off = 1; off <= NREQ; off++) begin
         k = (int'(ptr_i) + off) % NREQ;
         if (!found && req_i[k]) begin
            found    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDW'(k);
         end
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential shift-add multiplier core between NREQ clients, round-robin.
// Optional MULT_ARB_ZERO_BYPASS_EN: a zero operand skips the core and answers 0 one cycle after accept.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = idw(NREQ)
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_arbiter_if.slave  bus,
   output logic           busy,
   output logic           mul_rst,
   output logic [W-1:0]   mul_in1,
   output logic [W-1:0]   mul_in2,
   input  logic [2*W-1:0] mul_out,
   output state_t         dbg_state_o
);
   localparam int CW       = $clog2(W + 2);
   localparam int RUN_LAST = W + 1;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, id_q;
   logic [W-1:0]     a_q, b_q;
   logic [CW-1:0]    cnt_q;
   logic [2*W-1:0]   data_q;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gidx;
   logic [W-1:0]     sel_a, sel_b;
   logic             grant_en, zero_op;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   assign sel_a = bus.req_a[gidx*W +: W];
   assign sel_b = bus.req_b[gidx*W +: W];

`ifdef MULT_ARB_ZERO_BYPASS_EN
   assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      mul_rst  = 1'b1;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               grant_en = 1'b1;
               state_d  = zero_op ? RESP : LAUNCH;
            end
         end
         LAUNCH: begin
            mul_rst = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            mul_rst = 1'b0;
            if (cnt_q == CW'(RUN_LAST)) state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NREQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= gidx;
            ptr_q <= gidx;
            if (zero_op) data_q <= '0;
         end
         // Count 1 is the first RUN cycle; the core's product is final by the edge ending RUN_LAST.
         if (state_q == LAUNCH)   cnt_q <= CW'(1);
         else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);
         if (state_q == RUN && cnt_q == CW'(RUN_LAST)) data_q <= mul_out;
      end
   end

   assign bus.req_ready = grant_en ? gnt : '0;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = data_q;
   assign busy          = (state_q != IDLE);
   assign mul_in1       = a_q;
   assign mul_in2       = b_q;
   assign dbg_state_o   = state_q;
endmodule
